sb_trig_gate: RTL

Sits directly downstream of the single-bin trigger. Takes its one-cycle TRIG pulse and applies a programmable holdoff (dead time), readout-busy vetoing and an optional prescale, then emits the qualified trigger toward the event buffer logic. Also keeps per-second statistics latched on PPS: accepted triggers, lost triggers and dead-time cycles, for rate monitoring by software.

---
 rtl/sb_trig_gate_pkg.sv | 14 +
 rtl/sb_trig_gate_sat_counter.sv | 27 ++
 rtl/sb_trig_gate.sv | 116 +++++++++++
 3 files changed

// File: rtl/sb_trig_gate_pkg.sv
// sb_trig_gate_pkg: default widths and state encodings shared by the trigger gate
package sb_trig_gate_pkg;

    localparam int SB_GATE_CNT_WIDTH  = 24;
    localparam int SB_GATE_DEAD_WIDTH = 27;
    localparam int SB_GATE_HOLD_WIDTH = 16;
    localparam int SB_GATE_PS_WIDTH   = 16;

    typedef enum logic {
        SB_GATE_ST_IDLE    = 1'b0,
        SB_GATE_ST_HOLDOFF = 1'b1
    } sb_gate_state_t;

endpackage

// File: rtl/sb_trig_gate_sat_counter.sv
// sb_gate_sat_counter: saturating event counter that latches its value and restarts on clear
module sb_gate_sat_counter #(
    parameter int W = 24
) (
    input  logic         CLK120,
    input  logic         RESET,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] cnt;

    // an increment coinciding with clear belongs to the new interval
    always_ff @(posedge CLK120) begin
        if (RESET) begin
            cnt   <= '0;
            count <= '0;
        end else if (clr) begin
            count <= cnt;
            cnt   <= {{(W-1){1'b0}}, inc};
        end else if (inc && !(&cnt)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sb_trig_gate.sv
// sb_trig_gate: holdoff/busy/prescale trigger qualifier with PPS-latched stats (option SB_TRIG_GATE_PRESCALE_EN)
module sb_trig_gate
    import sb_trig_gate_pkg::*;
#(
    parameter int CNT_WIDTH  = SB_GATE_CNT_WIDTH,
    parameter int DEAD_WIDTH = SB_GATE_DEAD_WIDTH,
    parameter int HOLD_WIDTH = SB_GATE_HOLD_WIDTH,
    parameter int PS_WIDTH   = SB_GATE_PS_WIDTH
) (
    input  logic                  CLK120,
    input  logic                  RESET,
    input  logic                  TRIG_IN,
    input  logic                  ENABLE,
    input  logic                  BUSY,
    input  logic                  PPS,
    input  logic [HOLD_WIDTH-1:0] HOLDOFF,
    input  logic [PS_WIDTH-1:0]   PRESCALE,
    output logic                  TRIG_OUT,
    output logic [CNT_WIDTH-1:0]  RATE_COUNT,
    output logic [CNT_WIDTH-1:0]  LOST_COUNT,
    output logic [DEAD_WIDTH-1:0] DEAD_COUNT,
    output logic                  STATS_VALID
);

    sb_gate_state_t        state;
    logic [HOLD_WIDTH-1:0] hold_cnt;
    logic                  pps_q;
    logic                  ps_pass;

    wire cand     = TRIG_IN & ENABLE;
    wire in_hold  = state == SB_GATE_ST_HOLDOFF;
    wire eligible = cand & ~in_hold & ~BUSY;
    wire lost     = cand & (in_hold | BUSY);
    wire dead     = in_hold | BUSY;
    wire accept   = eligible & ps_pass;
    wire pps_edge = PPS & ~pps_q;

`ifdef SB_TRIG_GATE_PRESCALE_EN
    logic [PS_WIDTH-1:0] ps_cnt;
    logic [PS_WIDTH-1:0] ps_q;

    assign ps_pass = ps_cnt == '0;

    // 1-of-N selector over eligible triggers, restarted whenever PRESCALE changes
    always_ff @(posedge CLK120) begin
        if (RESET) begin
            ps_cnt <= '0;
            ps_q   <= '0;
        end else begin
            ps_q <= PRESCALE;
            if (PRESCALE != ps_q)
                ps_cnt <= '0;
            else if (eligible)
                ps_cnt <= (PRESCALE < PS_WIDTH'(2) || ps_cnt >= PRESCALE - 1'b1) ? '0 : ps_cnt + 1'b1;
        end
    end
`else
    logic unused_prescale;

    assign unused_prescale = ^PRESCALE;
    assign ps_pass         = 1'b1;
`endif

    // holdoff state machine with registered trigger and stats strobe
    always_ff @(posedge CLK120) begin
        if (RESET) begin
            state       <= SB_GATE_ST_IDLE;
            hold_cnt    <= '0;
            pps_q       <= 1'b0;
            TRIG_OUT    <= 1'b0;
            STATS_VALID <= 1'b0;
        end else begin
            pps_q       <= PPS;
            TRIG_OUT    <= accept;
            STATS_VALID <= pps_edge;
            case (state)
                SB_GATE_ST_IDLE: begin
                    if (accept) begin
                        hold_cnt <= HOLDOFF;
                        state    <= (HOLDOFF != '0) ? SB_GATE_ST_HOLDOFF : SB_GATE_ST_IDLE;
                    end
                end
                default: begin
                    hold_cnt <= hold_cnt - 1'b1;
                    if (hold_cnt == HOLD_WIDTH'(1))
                        state <= SB_GATE_ST_IDLE;
                end
            endcase
        end
    end

    sb_gate_sat_counter #(.W(CNT_WIDTH)) u_rate (
        .CLK120 (CLK120),
        .RESET  (RESET),
        .inc    (accept),
        .clr    (pps_edge),
        .count  (RATE_COUNT)
    );

    sb_gate_sat_counter #(.W(CNT_WIDTH)) u_lost (
        .CLK120 (CLK120),
        .RESET  (RESET),
        .inc    (lost),
        .clr    (pps_edge),
        .count  (LOST_COUNT)
    );

    sb_gate_sat_counter #(.W(DEAD_WIDTH)) u_dead (
        .CLK120 (CLK120),
        .RESET  (RESET),
        .inc    (dead),
        .clr    (pps_edge),
        .count  (DEAD_COUNT)
    );

endmodule
